controller_registers: RTL and testbench

Downstream consumer and scheduler for `controller_interface_m`. Issues one `start_fetch` pulse per video frame, waits for the serial fetch to finish, and captures the decoded button bytes. Derives sticky pressed/released edge flags from each capture and exposes them to the CPU as read-only, clear-on-read bus registers.

---
 rtl/controller_registers.sv | 138 +++++++++++++
 tb/tb_controller_registers.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/controller_registers.sv
// Frame-rate scheduler and CPU register front-end for controller_interface_m.
// Optional released-edge registers are built when CONTROLLER_REGISTERS_RELEASED_EN is defined.
module controller_registers #(
  parameter int NUM_CONTROLLERS = 2,
  parameter int SETTLE_CYCLES   = 16
) (
  input  logic                         clk,
  input  logic                         rst_B,
  input  logic                         frame_start,
  output logic                         start_fetch,
  input  logic [8*NUM_CONTROLLERS-1:0] controller_data_LIST,
  input  logic                         rd_en,
  input  logic [3:0]                   rd_addr,
  output logic [7:0]                   rd_data
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, CAPTURE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             start_nxt;
  logic             capture;
  logic             overrun_set;
  logic             overrun, valid;
  logic [7:0]       status;

  logic [NUM_CONTROLLERS-1:0][7:0] cur_q, pressed_q, press_edge;
  logic [NUM_CONTROLLERS-1:0]      clr_pressed;
  logic                            clr_overrun;
  logic [7:0]                      rd_mux;
`ifdef CONTROLLER_REGISTERS_RELEASED_EN
  logic [NUM_CONTROLLERS-1:0][7:0] released_q, rel_edge;
  logic [NUM_CONTROLLERS-1:0]      clr_released;
`endif

  // The counter also ticks in FETCH so the capture lands SETTLE_CYCLES after start_fetch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    start_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) begin
          start_nxt = 1'b1;
          cnt_nxt   = CNT_LOAD;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        cnt_nxt   = cnt - CNT_W'(1);
        state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == '0) state_nxt = CAPTURE;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign capture     = (state == CAPTURE);
  assign overrun_set = frame_start && (state != IDLE);
  assign status      = {5'b0, valid, overrun, state != IDLE};

  always_comb begin
    for (int i = 0; i < NUM_CONTROLLERS; i++) begin
      press_edge[i] = controller_data_LIST[8*i +: 8] & ~cur_q[i];
`ifdef CONTROLLER_REGISTERS_RELEASED_EN
      rel_edge[i]   = ~controller_data_LIST[8*i +: 8] & cur_q[i];
`endif
    end
  end

  // Read decode: returns pre-update values and raises clear strobes only on rd_en.
  always_comb begin
    rd_mux      = 8'h00;
    clr_pressed = '0;
    clr_overrun = 1'b0;
`ifdef CONTROLLER_REGISTERS_RELEASED_EN
    clr_released = '0;
`endif
    for (int i = 0; i < NUM_CONTROLLERS; i++) begin
      if (rd_addr == 4'(3*i)) rd_mux = cur_q[i];
      if (rd_addr == 4'(3*i + 1)) begin
        rd_mux         = pressed_q[i];
        clr_pressed[i] = rd_en;
      end
`ifdef CONTROLLER_REGISTERS_RELEASED_EN
      if (rd_addr == 4'(3*i + 2)) begin
        rd_mux          = released_q[i];
        clr_released[i] = rd_en;
      end
`endif
    end
    if (rd_addr == 4'hF) begin
      rd_mux      = status;
      clr_overrun = rd_en;
    end
  end

  always_ff @(posedge clk or negedge rst_B) begin
    if (!rst_B) begin
      state       <= IDLE;
      cnt         <= '0;
      start_fetch <= 1'b0;
      overrun     <= 1'b0;
      valid       <= 1'b0;
      rd_data     <= 8'h00;
      cur_q       <= '0;
      pressed_q   <= '0;
`ifdef CONTROLLER_REGISTERS_RELEASED_EN
      released_q  <= '0;
`endif
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      start_fetch <= start_nxt;
      overrun     <= (overrun & ~clr_overrun) | overrun_set;
      valid       <= valid | capture;
      if (rd_en) rd_data <= rd_mux;
      // Edges found by a capture survive a clear-on-read in the same cycle.
      for (int i = 0; i < NUM_CONTROLLERS; i++) begin
        pressed_q[i] <= (pressed_q[i] & ~{8{clr_pressed[i]}}) |
                        (capture ? press_edge[i] : 8'h00);
`ifdef CONTROLLER_REGISTERS_RELEASED_EN
        released_q[i] <= (released_q[i] & ~{8{clr_released[i]}}) |
                         (capture ? rel_edge[i] : 8'h00);
`endif
        if (capture) cur_q[i] <= controller_data_LIST[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_controller_registers.sv
// Directed, table-driven bench for controller_registers (2 controllers, 16 settle cycles).
module tb_controller_registers;
  localparam int N = 2;
  localparam int S = 16;

  logic         clk = 1'b0;
  logic         rst_B = 1'b0;
  logic         frame_start = 1'b0;
  logic         start_fetch;
  logic [15:0]  controller_data_LIST = 16'h0;
  logic         rd_en = 1'b0;
  logic [3:0]   rd_addr = 4'h0;
  logic [7:0]   rd_data;

  int total = 0;
  int bad = 0;
  int sf_cnt = 0;

  controller_registers #(.NUM_CONTROLLERS(N), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_B(rst_B), .frame_start(frame_start), .start_fetch(start_fetch),
    .controller_data_LIST(controller_data_LIST), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (start_fetch === 1'b1) sf_cnt++;

  typedef struct {
    logic [7:0] b0, b1;
    logic [7:0] c0, p0, r0, c1, p1, r1;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic do_read(input logic [3:0] a, output logic [7:0] d);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    rd_en   = 1'b0;
    d       = rd_data;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("start_fetch_t1", {31'b0, start_fetch}, 32'd1);
  endtask

  task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1);
    int s0;
    s0 = sf_cnt;
    controller_data_LIST = {b1, b0};
    pulse_frame();
    repeat (S + 1) tick();
    check("one_start_pulse", sf_cnt - s0, 32'd1);
  endtask

  function automatic logic [7:0] rel(input logic [7:0] v);
`ifdef CONTROLLER_REGISTERS_RELEASED_EN
    return v;
`else
    return 8'h00 & v;
`endif
  endfunction

  initial begin
    logic [7:0] d;
    logic [7:0] exp6[6];
    int s0;

    vecs[0] = '{8'h81, 8'h00, 8'h81, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[1] = '{8'h01, 8'hFF, 8'h01, 8'h00, 8'h80, 8'hFF, 8'hFF, 8'h00};
    vecs[2] = '{8'hFE, 8'h0F, 8'hFE, 8'hFE, 8'h01, 8'h0F, 8'h00, 8'hF0};
    vecs[3] = '{8'hFE, 8'h3C, 8'hFE, 8'h00, 8'h00, 8'h3C, 8'h30, 8'h03};

    repeat (3) tick();
    check("reset_rd_data", {24'b0, rd_data}, 32'h0);
    check("reset_start_fetch", {31'b0, start_fetch}, 32'h0);
    rst_B = 1'b1;
    tick();

    for (int a = 0; a < 16; a++) begin
      do_read(4'(a), d);
      check($sformatf("reset_addr%0h", a), {24'b0, d}, 32'h0);
    end
    s0 = sf_cnt;
    repeat (100) tick();
    check("idle_no_start_fetch", sf_cnt - s0, 32'd0);

    for (int v = 0; v < 4; v++) begin
      run_frame(vecs[v].b0, vecs[v].b1);
      exp6 = '{vecs[v].c0, vecs[v].p0, rel(vecs[v].r0),
               vecs[v].c1, vecs[v].p1, rel(vecs[v].r1)};
      for (int a = 0; a < 6; a++) begin
        do_read(4'(a), d);
        check($sformatf("vec%0d_addr%0d", v, a), {24'b0, d}, {24'b0, exp6[a]});
      end
      do_read(4'd1, d);
      check($sformatf("vec%0d_p0_cleared", v), {24'b0, d}, 32'h0);
      do_read(4'd4, d);
      check($sformatf("vec%0d_p1_cleared", v), {24'b0, d}, 32'h0);
      do_read(4'hF, d);
      check($sformatf("vec%0d_status", v), {24'b0, d}, 32'h04);
    end

    // Read pressed flags in the very cycle a new press is captured.
    run_frame(8'h01, 8'h3C);
    controller_data_LIST = {8'h3C, 8'h03};
    pulse_frame();
    repeat (S) tick();
    do_read(4'd1, d);
    check("cap_read_old_flags", {24'b0, d}, 32'h01);
    do_read(4'd1, d);
    check("cap_new_edge_kept", {24'b0, d}, 32'h02);
    do_read(4'd2, d);
    check("cap_released", {24'b0, d}, {24'b0, rel(8'hFE)});
    do_read(4'd0, d);
    check("cap_cur", {24'b0, d}, 32'h03);

    // Second frame_start while busy, including an overrun raised during a status read.
    s0 = sf_cnt;
    pulse_frame();
    repeat (2) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    do_read(4'hF, d);
    check("busy_status_overrun", {24'b0, d}, 32'h07);
    do_read(4'hF, d);
    check("overrun_cleared", {24'b0, d}, 32'h05);
    frame_start = 1'b1;
    do_read(4'hF, d);
    frame_start = 1'b0;
    check("overrun_race_read", {24'b0, d}, 32'h05);
    do_read(4'hF, d);
    check("overrun_race_kept", {24'b0, d}, 32'h07);
    do_read(4'hF, d);
    check("overrun_race_cleared", {24'b0, d}, 32'h05);
    repeat (20) tick();
    check("overrun_single_pulse", sf_cnt - s0, 32'd1);
    do_read(4'hF, d);
    check("status_after_frame", {24'b0, d}, 32'h04);

    // Reset in the middle of WAIT with a full press pending.
    s0 = sf_cnt;
    controller_data_LIST = {8'h3C, 8'hFF};
    pulse_frame();
    repeat (6) tick();
    rst_B = 1'b0;
    tick();
    check("midreset_rd_data", {24'b0, rd_data}, 32'h0);
    check("midreset_start_fetch", {31'b0, start_fetch}, 32'h0);
    rst_B = 1'b1;
    repeat (30) tick();
    check("midreset_pulses", sf_cnt - s0, 32'd1);
    for (int a = 0; a < 16; a++) begin
      do_read(4'(a), d);
      check($sformatf("midreset_addr%0h", a), {24'b0, d}, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
